ps2_key_decoder: RTL and testbench

- Sequential PS/2 Set-2 scancode decoder for the keyboard experiment.
- Sits between the PS/2 byte receiver and the display/console logic.
- Tracks the break (F0) and extended (E0) prefixes, Shift and Caps Lock state, and the currently held key.
- Emits case-correct ASCII press events through a parametrised output FIFO with a valid/ready handshake, and keeps a press counter.

---
 rtl/ps2_pkg.sv | 13 +
 rtl/ps2_ascii_lut.sv | 53 +++++
 rtl/ps2_key_decoder.sv | 91 +++++++++
 tb/tb_ps2_key_decoder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared Set-2 scancode constants, decoder FSM states and ASCII case offset.
package ps2_pkg;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] CASE_OFS  = 8'h20;
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
  function automatic logic is_shift(input logic [7:0] c);
    return c == SC_LSHIFT || c == SC_RSHIFT;
  endfunction
endpackage

// File: rtl/ps2_ascii_lut.sv
// ps2_ascii_lut: maps Set-2 make codes of letters and digits to uppercase ASCII.
module ps2_ascii_lut (
  input  logic [7:0] code,
  output logic       hit,
  output logic       is_letter,
  output logic [7:0] upper
);
  always_comb begin
    upper = 8'h00;
    case (code)
      8'h1C: upper = 8'h41;
      8'h32: upper = 8'h42;
      8'h21: upper = 8'h43;
      8'h23: upper = 8'h44;
      8'h24: upper = 8'h45;
      8'h2B: upper = 8'h46;
      8'h34: upper = 8'h47;
      8'h33: upper = 8'h48;
      8'h43: upper = 8'h49;
      8'h3B: upper = 8'h4A;
      8'h42: upper = 8'h4B;
      8'h4B: upper = 8'h4C;
      8'h3A: upper = 8'h4D;
      8'h31: upper = 8'h4E;
      8'h44: upper = 8'h4F;
      8'h4D: upper = 8'h50;
      8'h15: upper = 8'h51;
      8'h2D: upper = 8'h52;
      8'h1B: upper = 8'h53;
      8'h2C: upper = 8'h54;
      8'h3C: upper = 8'h55;
      8'h2A: upper = 8'h56;
      8'h1D: upper = 8'h57;
      8'h22: upper = 8'h58;
      8'h35: upper = 8'h59;
      8'h1A: upper = 8'h5A;
      8'h45: upper = 8'h30;
      8'h16: upper = 8'h31;
      8'h1E: upper = 8'h32;
      8'h26: upper = 8'h33;
      8'h25: upper = 8'h34;
      8'h2E: upper = 8'h35;
      8'h36: upper = 8'h36;
      8'h3D: upper = 8'h37;
      8'h3E: upper = 8'h38;
      8'h46: upper = 8'h39;
      default: upper = 8'h00;
    endcase
  end
  // letters live in 0x41-0x5A, digits in 0x30-0x39: bit 6 separates them
  assign hit = upper != 8'h00;
  assign is_letter = upper[6];
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: Set-2 scancode decoder tracking prefixes, Shift/Caps and the held key,
// emitting ASCII press events through a show-ahead FIFO with valid/ready.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int CASE_MODE     = 1,
  parameter int REPEAT_FILTER = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             scan_valid,
  input  logic [7:0]       scan_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_ascii,
  output logic             key_held,
  output logic [7:0]       held_ascii,
  output logic             caps_on,
  output logic             shift_on,
  output logic [CNT_W-1:0] press_cnt,
  output logic             overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  state_t state, state_nx;
  logic hit, is_letter, is_make, is_brk, press, pop, full, do_write, caps_down;
  logic [7:0] upper, ascii, held_code;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  ps2_ascii_lut u_lut (.code(scan_data), .hit(hit), .is_letter(is_letter), .upper(upper));
  always_comb begin
    state_nx = !scan_valid ? state :
               state == IDLE ? (scan_data == SC_BREAK ? BRK : scan_data == SC_EXT ? EXT : IDLE) :
               (state == EXT && scan_data == SC_BREAK) ? EXT_BRK : IDLE;
  end
  assign is_make = scan_valid && state == IDLE && scan_data != SC_BREAK && scan_data != SC_EXT;
  assign is_brk = scan_valid && state == BRK;
  assign press = is_make && hit && !(REPEAT_FILTER != 0 && scan_data == held_code);
  // case comes from the registered shift/caps, i.e. the state before this byte
  assign ascii = upper + ((is_letter && CASE_MODE != 0 && !(shift_on ^ caps_on)) ? CASE_OFS : 8'h00);
  assign out_valid = count != '0;
  assign out_ascii = out_valid ? mem[rd_ptr] : 8'h00;
  assign pop = out_valid && out_ready;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign do_write = press && (!full || pop);
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= ascii;
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      press_cnt <= '0;
      shift_on <= 1'b0;
      caps_on <= 1'b0;
      caps_down <= 1'b0;
      key_held <= 1'b0;
      held_ascii <= 8'h00;
      held_code <= 8'h00;
    end else begin
      state <= state_nx;
      wr_ptr <= wr_ptr + AW'(do_write);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(do_write) - (AW+1)'(pop);
      if (press && !do_write) overflow <= 1'b1;
      if (press) begin
        press_cnt <= press_cnt + CNT_W'(1);
        held_code <= scan_data;
        held_ascii <= ascii;
        key_held <= 1'b1;
      end
      if (is_make && is_shift(scan_data)) shift_on <= 1'b1;
      if (is_brk && is_shift(scan_data)) shift_on <= 1'b0;
      if (is_make && scan_data == SC_CAPS) begin
        caps_down <= 1'b1;
        if (!caps_down) caps_on <= !caps_on;
      end
      if (is_brk && scan_data == SC_CAPS) caps_down <= 1'b0;
      if (is_brk && scan_data == held_code) begin
        key_held <= 1'b0;
        held_ascii <= 8'h00;
        held_code <= 8'h00;
      end
    end
  end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed scancode sequences checked against a queue-based key model every cycle.
module tb_ps2_key_decoder;
  logic clk = 0, clrn = 0, scan_valid = 0, out_ready = 0;
  logic [7:0] scan_data = 8'h00;
  logic out_valid, key_held, caps_on, shift_on, overflow;
  logic [7:0] out_ascii, held_ascii, press_cnt;
  logic ov2, kh2, co2, so2, of2;
  logic [7:0] oa2, ha2;
  logic [2:0] pc2;
  int checks = 0, failures = 0, pops2 = 0;
  logic [7:0] popv [8];
  always #5 clk = ~clk;

  ps2_key_decoder u_dut (
    .clk(clk), .clrn(clrn), .scan_valid(scan_valid), .scan_data(scan_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ascii(out_ascii),
    .key_held(key_held), .held_ascii(held_ascii), .caps_on(caps_on),
    .shift_on(shift_on), .press_cnt(press_cnt), .overflow(overflow));

  ps2_key_decoder #(.REPEAT_FILTER(0), .CNT_W(3)) u_rf0 (
    .clk(clk), .clrn(clrn), .scan_valid(scan_valid), .scan_data(scan_data),
    .out_valid(ov2), .out_ready(1'b1), .out_ascii(oa2),
    .key_held(kh2), .held_ascii(ha2), .caps_on(co2),
    .shift_on(so2), .press_cnt(pc2), .overflow(of2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference key model: letters by alphabet position, digits by value
  logic [7:0] let_tab [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dig_tab [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] q [$];
  bit m_brk, m_ext, m_shift, m_caps, m_capsdn, m_ovf, m_held;
  logic [7:0] m_hcode, m_hasc, m_cnt;

  function automatic void lookup(input logic [7:0] c, output bit h, output logic [7:0] a);
    h = 0;
    a = 8'h00;
    for (int i = 0; i < 26; i++)
      if (c == let_tab[i]) begin
        h = 1;
        a = (m_shift ^ m_caps) ? 8'(8'h41 + i) : 8'(8'h61 + i);
      end
    for (int i = 0; i < 10; i++)
      if (c == dig_tab[i]) begin
        h = 1;
        a = 8'(8'h30 + i);
      end
  endfunction

  always @(posedge clk or negedge clrn) begin
    bit popped, full, press, h;
    logic [7:0] a;
    if (!clrn) begin
      q.delete();
      {m_brk, m_ext, m_shift, m_caps, m_capsdn, m_ovf, m_held} = '0;
      m_hcode = 0;
      m_hasc = 0;
      m_cnt = 0;
    end else begin
      popped = out_ready && q.size() != 0;
      full = q.size() == 4;
      press = 0;
      a = 0;
      if (scan_valid) begin
        if (m_ext) begin
          if (!m_brk && scan_data == 8'hF0) m_brk = 1;
          else begin
            m_ext = 0;
            m_brk = 0;
          end
        end else if (m_brk) begin
          m_brk = 0;
          if (scan_data == 8'h12 || scan_data == 8'h59) m_shift = 0;
          if (scan_data == 8'h58) m_capsdn = 0;
          if (scan_data == m_hcode) begin
            m_held = 0;
            m_hcode = 0;
            m_hasc = 0;
          end
        end else if (scan_data == 8'hF0) m_brk = 1;
        else if (scan_data == 8'hE0) m_ext = 1;
        else begin
          lookup(scan_data, h, a);
          press = h && scan_data != m_hcode;
          if (scan_data == 8'h12 || scan_data == 8'h59) m_shift = 1;
          if (scan_data == 8'h58) begin
            if (!m_capsdn) m_caps = !m_caps;
            m_capsdn = 1;
          end
          if (press) begin
            m_held = 1;
            m_hcode = scan_data;
            m_hasc = a;
          end
        end
      end
      if (popped) void'(q.pop_front());
      if (press) begin
        m_cnt++;
        if (full && !popped) m_ovf = 1;
        else q.push_back(a);
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("out_ascii", 32'(out_ascii), 32'(q.size() != 0 ? q[0] : 8'h00));
    chk("key_held", 32'(key_held), 32'(m_held));
    chk("held_ascii", 32'(held_ascii), 32'(m_hasc));
    chk("caps_on", 32'(caps_on), 32'(m_caps));
    chk("shift_on", 32'(shift_on), 32'(m_shift));
    chk("press_cnt", 32'(press_cnt), 32'(m_cnt));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (clrn && ov2) pops2++;
  end

  task automatic send(input logic [7:0] b);
    scan_valid = 1;
    scan_data = b;
    @(posedge clk);
    #1 scan_valid = 0;
  endtask

  task automatic drain(input int exp_n, input string name);
    int n = 0;
    out_ready = 1;
    for (int i = 0; i < 20 && out_valid; i++) begin
      if (n < 8) popv[n] = out_ascii;
      n++;
      @(posedge clk);
      #1;
    end
    out_ready = 0;
    chk(name, 32'(n), 32'(exp_n));
  endtask

  initial begin
    int pb;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_cnt", 32'(press_cnt), 0);
    chk("rst_held", 32'(held_ascii), 0);
    clrn = 1;
    @(posedge clk);
    #1;
    send(8'h1C);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_ascii", 32'(out_ascii), 32'h61);
    chk("t1_cnt", 32'(press_cnt), 1);
    chk("t1_held", 32'(key_held), 1);
    send(8'hF0); send(8'h1C);
    chk("t1_rel", 32'(key_held), 0);
    chk("t1_rel_ascii", 32'(held_ascii), 0);
    drain(1, "t1_pops");
    chk("t1_pop0", 32'(popv[0]), 32'h61);
    send(8'h12);
    chk("t2_shift", 32'(shift_on), 1);
    send(8'h1C);
    chk("t2_ascii", 32'(out_ascii), 32'h41);
    chk("t2_held_ascii", 32'(held_ascii), 32'h41);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    chk("t2_unshift", 32'(shift_on), 0);
    send(8'h58);
    chk("t2_caps", 32'(caps_on), 1);
    send(8'hF0); send(8'h58); send(8'h1C);
    drain(2, "t2_pops");
    chk("t2_caps_a", 32'(popv[1]), 32'h41);
    send(8'hF0); send(8'h1C); send(8'h58); send(8'h58);
    chk("t2_caps_rep", 32'(caps_on), 0);
    send(8'hF0); send(8'h58);
    pb = pops2;
    repeat (5) send(8'h1C);
    send(8'hF0); send(8'h1C);
    chk("t3_cnt", 32'(press_cnt), 4);
    drain(1, "t3_pops");
    chk("t3_rf0_wrap", 32'(pc2), 0);
    chk("t3_rf0_pops", 32'(pops2 - pb), 5);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h0D);
    chk("t4_none", 32'(out_valid), 0);
    send(8'h16);
    chk("t4_digit", 32'(out_ascii), 32'h31);
    chk("t4_cnt", 32'(press_cnt), 5);
    send(8'hF0); send(8'h16);
    drain(1, "t4_pops");
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1B); send(8'hF0); send(8'h1B);
    send(8'h23); send(8'hF0); send(8'h23); send(8'h2B); send(8'hF0); send(8'h2B);
    chk("t5_no_ovf", 32'(overflow), 0);
    send(8'h34);
    chk("t5_ovf", 32'(overflow), 1);
    send(8'hF0); send(8'h34);
    chk("t5_cnt", 32'(press_cnt), 10);
    drain(4, "t5_pops");
    chk("t5_p0", 32'(popv[0]), 32'h61);
    chk("t5_p1", 32'(popv[1]), 32'h73);
    chk("t5_p2", 32'(popv[2]), 32'h64);
    chk("t5_p3", 32'(popv[3]), 32'h66);
    send(8'hF0);
    clrn = 0;
    #2;
    chk("t6_cnt", 32'(press_cnt), 0);
    chk("t6_ovf", 32'(overflow), 0);
    chk("t6_caps_shift", 32'({caps_on, shift_on, key_held}), 0);
    @(posedge clk);
    #1 clrn = 1;
    @(posedge clk);
    #1;
    send(8'h1C);
    chk("t6_make", 32'(out_ascii), 32'h61);
    chk("t6_valid", 32'(out_valid), 1);
    chk("t6_cnt1", 32'(press_cnt), 1);
    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
